pipe_control: RTL and testbench
===============================

// Module: pipe_control
// PURPOSE
//  Sequencing/hazard controller for the 5-stage Y-86 pipeline (F,D,E,M,W).
//  Generates per-stage stall/bubble controls and set_cc, and runs the run/pause/halt FSM.
//  Freezes the whole pipeline on exception, keeps cycle/retire counters.
//  Sits beside the stage datapaths; fetch PC selection itself stays in fetch.
// PARAMETERS
//  CNT_W   64  width of cycle_cnt and retire_cnt (wrap modulo 2^CNT_W)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      IDLE/PAUSE -> RUN (1-cycle pulse)
//  step         in   1      IDLE/PAUSE -> STEP (advance exactly one cycle)
//  pause        in   1      RUN -> PAUSE
//  D_icode      in   4      icode in D register
//  d_srcA,d_srcB in  4      decode source regs (15 = none)
//  E_icode,E_dstM in 4      E register icode / dstM
//  e_Cnd        in   1      execute-stage condition
//  M_icode      in   4      M register icode
//  m_stat,W_stat in  4      memory-stage / W register status
//  W_icode      in   4      W register icode
//  F_stall,D_stall,E_stall,M_stall,W_stall  out 1  hold stage register
//  D_bubble,E_bubble,M_bubble               out 1  load nop into stage register
//  set_cc       out  1      execute may update condition codes
//  state        out  2      0 IDLE,1 RUN,2 PAUSE(incl. STEP),3 HALT
//  halted       out  1      state==HALT
//  cpu_stat     out  4      latched terminating W_stat (SAOK while not halted)
//  cycle_cnt    out  CNT_W  cycles spent in RUN or STEP
//  retire_cnt   out  CNT_W  instructions retired
// BEHAVIOUR
//  Stat: SAOK=4'b1000 SHLT=4'b0100 SADR=4'b0010 SINS=4'b0001. Icodes: NOP=1 MRMOVQ=5
//   OPQ=6 JXX=7 RET=9 POPQ=B. RNONE=15.
//  Reset: state=IDLE, halted=0, cpu_stat=SAOK, counters=0; outputs freeze (below).
//  Freeze (IDLE,PAUSE,HALT): all *_stall=1, all *_bubble=0, set_cc=0.
//  Hazard terms (combinational, evaluated in RUN/STEP only):
//   lu  = E_icode in{MRMOVQ,POPQ} & E_dstM!=RNONE & E_dstM in{d_srcA,d_srcB}
//   ret = RET in {D_icode,E_icode,M_icode};  mp = E_icode==JXX & !e_Cnd
//   exc_m = m_stat in{SADR,SINS,SHLT}; exc_w = W_stat in{SADR,SINS,SHLT}
//  Run outputs: F_stall=lu|ret; D_stall=lu; D_bubble=mp|(!lu&ret);
//   E_bubble=mp|lu; M_bubble=exc_m|exc_w; W_stall=exc_w; E_stall=M_stall=0;
//   set_cc = E_icode==OPQ & !exc_m & !exc_w.
//  Combos: lu+ret -> D_stall=1,D_bubble=0; mp+ret in D -> F_stall=1,D_bubble=1.
//   D_stall and D_bubble never both 1.
//  FSM (registered, priority top-down each cycle):
//   any state: exc_w & state in{RUN,STEP} -> HALT, cpu_stat<=W_stat (same edge).
//   IDLE/PAUSE: start -> RUN; else step -> STEP (internal sub-state of PAUSE).
//   STEP: one cycle of Run outputs, then PAUSE.  RUN: pause -> PAUSE.
//   HALT: sticky until rst_n; start/step/pause ignored.
//  Counters: cycle_cnt+1 each cycle in RUN/STEP. retire_cnt+1 when in RUN/STEP,
//   W_icode!=NOP, W_stat==SAOK, !W_stall. Both wrap to 0 at all-ones.
//  Reset asserted mid-run: immediate async return to reset values; pipeline regs
//   reset separately.
// STRUCTURE
//  y86_pkg: icode constants, stat codes, RNONE, state encoding.
//  Sub-module pipe_hazard_detect: pure combinational lu/ret/mp/exc terms.
//  pipe_control holds FSM, output muxing, counters.
// TESTING
//  1 Reset then idle 5 cyc -> all stalls=1, counters=0, state=0; start -> state=1 next cyc.
//  2 E_icode=5,E_dstM=3,d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0; E_dstM=15 -> all 0.
//  3 E_icode=7,e_Cnd=0 -> D_bubble=1,E_bubble=1,F_stall=0; with D_icode=9 also F_stall=1.
//  4 D_icode=9 only -> F_stall=1,D_bubble=1; then lu also true -> D_stall=1,D_bubble=0.
//  5 W_stat=0100,W_icode=0 in RUN -> next cyc state=3,cpu_stat=0100, stalls=1; start ignored.
//  6 PAUSE,step pulse -> cycle_cnt +1 exactly, state back to 2; OPQ retire counted once.

Source files
------------

// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg : Y-86 icodes, status codes and pipeline-controller state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    // STEP is a private sub-state of PAUSE; it never appears on the state port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HALT  = 3'd3,
        ST_STEP  = 3'd4
    } ctrl_state_t;

    function automatic logic is_exception(input logic [3:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

    function automatic logic [1:0] state_code(input ctrl_state_t st);
        case (st)
            ST_IDLE:  return 2'd0;
            ST_RUN:   return 2'd1;
            ST_HALT:  return 2'd3;
            default:  return 2'd2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_control_if.sv
// ----------------------------------------------------------------------------
// pipe_control_if : stage-status inputs and stall/bubble/status outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pipe_control_if #(
    parameter int CNT_W = 64
);
    logic             start;
    logic             step;
    logic             pause;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic [3:0]       W_icode;

    logic             F_stall;
    logic             D_stall;
    logic             E_stall;
    logic             M_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             set_cc;
    logic [1:0]       state;
    logic             halted;
    logic [3:0]       cpu_stat;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  start, step, pause, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
               e_Cnd, M_icode, m_stat, W_stat, W_icode,
        output F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, set_cc,
               state, halted, cpu_stat, cycle_cnt, retire_cnt
    );

    modport slave (
        output start, step, pause, D_icode, d_srcA, d_srcB, E_icode, E_dstM,
               e_Cnd, M_icode, m_stat, W_stat, W_icode,
        input  F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, set_cc,
               state, halted, cpu_stat, cycle_cnt, retire_cnt
    );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
// ----------------------------------------------------------------------------
// pipe_hazard_detect : combinational load-use / ret / mispredict / exception terms
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       lu,
    output logic       ret,
    output logic       mp,
    output logic       exc_m,
    output logic       exc_w
);

    logic e_is_load;

    assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

    assign lu    = e_is_load && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp    = (E_icode == I_JXX) && !e_Cnd;
    assign exc_m = is_exception(m_stat);
    assign exc_w = is_exception(W_stat);

endmodule

`default_nettype wire

// File: rtl/pipe_control.sv
// ----------------------------------------------------------------------------
// pipe_control : Y-86 pipeline run/pause/halt FSM, stall/bubble muxing, counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_control
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_control_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t      cur_state;
    logic [3:0]       stat_latch;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    logic lu, ret, mp, exc_m, exc_w;
    logic active;
    logic retire;

    pipe_hazard_detect u_hazard (
        .D_icode (bus.D_icode),
        .d_srcA  (bus.d_srcA),
        .d_srcB  (bus.d_srcB),
        .E_icode (bus.E_icode),
        .E_dstM  (bus.E_dstM),
        .e_Cnd   (bus.e_Cnd),
        .M_icode (bus.M_icode),
        .m_stat  (bus.m_stat),
        .W_stat  (bus.W_stat),
        .lu      (lu),
        .ret     (ret),
        .mp      (mp),
        .exc_m   (exc_m),
        .exc_w   (exc_w)
    );

    assign active = (cur_state == ST_RUN) || (cur_state == ST_STEP);

    // Outside RUN/STEP every stage holds; nothing is bubbled and CCs are frozen.
    always_comb begin
        bus.F_stall  = 1'b1;
        bus.D_stall  = 1'b1;
        bus.E_stall  = 1'b1;
        bus.M_stall  = 1'b1;
        bus.W_stall  = 1'b1;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.set_cc   = 1'b0;
        if (active) begin
            bus.F_stall  = lu | ret;
            bus.D_stall  = lu;
            bus.E_stall  = 1'b0;
            bus.M_stall  = 1'b0;
            bus.W_stall  = exc_w;
            bus.D_bubble = mp | (~lu & ret);
            bus.E_bubble = mp | lu;
            bus.M_bubble = exc_m | exc_w;
            bus.set_cc   = (bus.E_icode == I_OPQ) & ~exc_m & ~exc_w;
        end
    end

    assign retire = active && (bus.W_icode != I_NOP) &&
                    (bus.W_stat == STAT_AOK) && !bus.W_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= ST_IDLE;
            stat_latch   <= STAT_AOK;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            if (active) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
            if (retire) begin
                retire_count <= retire_count + CNT_ONE;
            end
            if (active && exc_w) begin
                cur_state  <= ST_HALT;
                stat_latch <= bus.W_stat;
            end else begin
                case (cur_state)
                    ST_IDLE, ST_PAUSE: begin
                        if (bus.start) begin
                            cur_state <= ST_RUN;
                        end else if (bus.step) begin
                            cur_state <= ST_STEP;
                        end
                    end
                    ST_STEP: cur_state <= ST_PAUSE;
                    ST_RUN: begin
                        if (bus.pause) begin
                            cur_state <= ST_PAUSE;
                        end
                    end
                    ST_HALT: cur_state <= ST_HALT;
                    default: cur_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.state      = state_code(cur_state);
    assign bus.halted     = (cur_state == ST_HALT);
    assign bus.cpu_stat   = stat_latch;
    assign bus.cycle_cnt  = cycle_count;
    assign bus.retire_cnt = retire_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_control.sv
// ----------------------------------------------------------------------------
// tb_pipe_control : directed and randomized checks of pipe_control against a model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_control;

    // Narrow counters so wrap-around is reached during the random phase.
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    // Model: 0 IDLE, 1 RUN, 2 PAUSE, 3 HALT, 4 STEP
    int          ms;
    logic [3:0]  m_cpu;
    logic [CW-1:0] m_cyc;
    logic [CW-1:0] m_ret;
    int          halt_cycles;

    pipe_control_if #(.CNT_W(CW)) ifc ();

    pipe_control #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bad_stat(input logic [3:0] s);
        return (s == 4'b0100) || (s == 4'b0010) || (s == 4'b0001);
    endfunction

    task automatic model_reset();
        ms    = 0;
        m_cpu = 4'b1000;
        m_cyc = '0;
        m_ret = '0;
    endtask

    // Compare every DUT output against what the rules demand for the current
    // model state and the inputs currently driven.
    task automatic check_all();
        bit run, lu, rt, mp, em, ew;
        bit fs, ds, ws, db, eb, mb, sc;
        int es;
        run = (ms == 1) || (ms == 4);
        lu  = (ifc.E_icode == 4'h5 || ifc.E_icode == 4'hB) && ifc.E_dstM != 4'hF &&
              (ifc.E_dstM == ifc.d_srcA || ifc.E_dstM == ifc.d_srcB);
        rt  = ifc.D_icode == 4'h9 || ifc.E_icode == 4'h9 || ifc.M_icode == 4'h9;
        mp  = ifc.E_icode == 4'h7 && !ifc.e_Cnd;
        em  = bad_stat(ifc.m_stat);
        ew  = bad_stat(ifc.W_stat);
        if (run) begin
            fs = lu || rt;  ds = lu;  ws = ew;
            db = mp || (!lu && rt);  eb = mp || lu;  mb = em || ew;
            sc = ifc.E_icode == 4'h6 && !em && !ew;
        end else begin
            fs = 1; ds = 1; ws = 1; db = 0; eb = 0; mb = 0; sc = 0;
        end
        es = (ms == 4) ? 2 : ms;
        chk("F_stall",   64'(ifc.F_stall),  64'(fs));
        chk("D_stall",   64'(ifc.D_stall),  64'(ds));
        chk("E_stall",   64'(ifc.E_stall),  64'(!run));
        chk("M_stall",   64'(ifc.M_stall),  64'(!run));
        chk("W_stall",   64'(ifc.W_stall),  64'(ws));
        chk("D_bubble",  64'(ifc.D_bubble), 64'(db));
        chk("E_bubble",  64'(ifc.E_bubble), 64'(eb));
        chk("M_bubble",  64'(ifc.M_bubble), 64'(mb));
        chk("set_cc",    64'(ifc.set_cc),   64'(sc));
        chk("state",     64'(ifc.state),    64'(es));
        chk("halted",    64'(ifc.halted),   64'(ms == 3));
        chk("cpu_stat",  64'(ifc.cpu_stat), 64'(m_cpu));
        chk("cycle_cnt", 64'(ifc.cycle_cnt),  64'(m_cyc));
        chk("retire_cnt",64'(ifc.retire_cnt), 64'(m_ret));
    endtask

    task automatic model_step();
        bit run;
        run = (ms == 1) || (ms == 4);
        if (run) begin
            m_cyc = m_cyc + 1'b1;
            if (ifc.W_icode != 4'h1 && ifc.W_stat == 4'b1000) m_ret = m_ret + 1'b1;
        end
        if (run && bad_stat(ifc.W_stat)) begin
            ms    = 3;
            m_cpu = ifc.W_stat;
        end else if (ms == 0 || ms == 2) begin
            if (ifc.start) ms = 1;
            else if (ifc.step) ms = 4;
        end else if (ms == 4) begin
            ms = 2;
        end else if (ms == 1 && ifc.pause) begin
            ms = 2;
        end
    endtask

    // Called at posedge+1: check before the next edge, then advance the model.
    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_state", 64'(ifc.state), 64'd0);
        chk("async_rst_cycle", 64'(ifc.cycle_cnt), 64'd0);
        chk("async_rst_retire", 64'(ifc.retire_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic benign();
        ifc.start = 0; ifc.step = 0; ifc.pause = 0;
        ifc.D_icode = 4'h1; ifc.E_icode = 4'h1; ifc.M_icode = 4'h1; ifc.W_icode = 4'h1;
        ifc.d_srcA = 4'hF; ifc.d_srcB = 4'hF; ifc.E_dstM = 4'hF; ifc.e_Cnd = 1'b1;
        ifc.m_stat = 4'b1000; ifc.W_stat = 4'b1000;
    endtask

    function automatic logic [3:0] rand_reg();
        int r;
        r = $urandom_range(4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    function automatic logic [3:0] rand_bad_stat();
        case ($urandom_range(3))
            0: return 4'b0100;
            1: return 4'b0010;
            2: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic randomize_inputs();
        ifc.start   = ($urandom_range(9) == 0);
        ifc.pause   = ($urandom_range(14) == 0);
        ifc.step    = ($urandom_range(7) == 0);
        ifc.D_icode = 4'($urandom_range(11));
        ifc.E_icode = 4'($urandom_range(11));
        ifc.M_icode = 4'($urandom_range(11));
        ifc.W_icode = 4'($urandom_range(11));
        ifc.d_srcA  = rand_reg();
        ifc.d_srcB  = rand_reg();
        ifc.E_dstM  = rand_reg();
        ifc.e_Cnd   = 1'($urandom_range(1));
        ifc.m_stat  = ($urandom_range(19) == 0) ? rand_bad_stat() : 4'b1000;
        ifc.W_stat  = ($urandom_range(79) == 0) ? rand_bad_stat() : 4'b1000;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        benign();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: frozen, counters at zero, start takes effect next cycle.
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            ifc.start = 0; ifc.step = 0;
            cycle();
        end
        chk("idle_F_stall", 64'(ifc.F_stall), 64'd1);
        chk("idle_state", 64'(ifc.state), 64'd0);
        chk("idle_cycle", 64'(ifc.cycle_cnt), 64'd0);
        benign();
        ifc.start = 1;
        cycle();
        ifc.start = 0;
        chk("start_state", 64'(ifc.state), 64'd1);

        // Load-use.
        ifc.E_icode = 4'h5; ifc.E_dstM = 4'h3; ifc.d_srcA = 4'h3;
        #1;
        chk("lu_F_stall", 64'(ifc.F_stall), 64'd1);
        chk("lu_D_stall", 64'(ifc.D_stall), 64'd1);
        chk("lu_E_bubble", 64'(ifc.E_bubble), 64'd1);
        chk("lu_D_bubble", 64'(ifc.D_bubble), 64'd0);
        cycle();
        ifc.E_dstM = 4'hF;
        #1;
        chk("lu_none", 64'({ifc.F_stall, ifc.D_stall, ifc.E_bubble, ifc.D_bubble}), 64'd0);
        cycle();

        // Mispredict, alone and with ret in D.
        benign();
        ifc.E_icode = 4'h7; ifc.e_Cnd = 1'b0;
        #1;
        chk("mp_bubbles", 64'({ifc.D_bubble, ifc.E_bubble, ifc.F_stall}), 64'b110);
        cycle();
        ifc.D_icode = 4'h9;
        #1;
        chk("mp_ret_F_stall", 64'(ifc.F_stall), 64'd1);
        cycle();

        // Ret alone, then ret combined with load-use.
        benign();
        ifc.D_icode = 4'h9;
        #1;
        chk("ret_ctrl", 64'({ifc.F_stall, ifc.D_bubble, ifc.D_stall}), 64'b110);
        cycle();
        ifc.E_icode = 4'hB; ifc.E_dstM = 4'h3; ifc.d_srcB = 4'h3;
        #1;
        chk("lu_ret_ctrl", 64'({ifc.D_stall, ifc.D_bubble}), 64'b10);
        cycle();

        // Single step from PAUSE counts one cycle and one OPQ retirement.
        benign();
        do_reset();
        ifc.start = 1;
        cycle();
        ifc.start = 0; ifc.pause = 1;
        cycle();
        ifc.pause = 0; ifc.W_icode = 4'h6;
        cycle();
        ifc.step = 1;
        cycle();
        chk("step_state", 64'(ifc.state), 64'd2);
        ifc.step = 0;
        cycle();
        cycle();
        chk("step_cycle", 64'(ifc.cycle_cnt), 64'd2);
        chk("step_retire", 64'(ifc.retire_cnt), 64'd1);
        chk("step_pause_state", 64'(ifc.state), 64'd2);

        // Halt from W-stage status; start is ignored once halted.
        benign();
        ifc.start = 1;
        cycle();
        ifc.start = 0; ifc.W_stat = 4'b0100; ifc.W_icode = 4'h0;
        cycle();
        chk("halt_state", 64'(ifc.state), 64'd3);
        chk("halt_cpu_stat", 64'(ifc.cpu_stat), 64'b0100);
        chk("halt_stalls", 64'({ifc.F_stall, ifc.D_stall, ifc.E_stall, ifc.M_stall, ifc.W_stall}), 64'h1F);
        benign();
        ifc.start = 1;
        cycle();
        chk("halt_sticky", 64'(ifc.state), 64'd3);
        ifc.start = 0;
        do_reset();

        // Randomized run; recover from HALT by reset, with occasional mid-run resets.
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            randomize_inputs();
            cycle();
            if (ms == 3) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(499) == 0) begin
                halt_cycles = 0;
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
